uart_rx: RTL and testbench

- UART receiver: 8N1, LSB first, 16x oversampling. Converts the asynchronous serial line into parallel bytes.
- Counterpart of the UART transmit path. Sits between the board RX pin and the lab's command/loopback logic.
- Has its own oversample divider that restarts on each start edge, so sampling is aligned to the frame rather than to a free-running baud tick.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_os_tick_gen.sv | 39 +++
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned OVERSAMPLE        = 16;
  localparam int unsigned DATA_BITS         = 8;
  localparam int unsigned START_SAMPLE_TICK = 8;
  localparam int unsigned TICK_W            = 4;
  localparam int unsigned BIT_IDX_W         = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample divider: one-cycle tick every DIV clocks, restartable by clear.
module uart_os_tick_gen #(
  parameter int unsigned DIV = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count; tick is registered so it is high in the cycle the count sits at LAST.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
    tick_d = (cnt_d == LAST);
  end

  // Counter and tick registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, 16x oversampling aligned to the start edge.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned OS_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);

  if (OS_DIV < 2) begin : g_os_div_check
    $error("uart_rx: CLK_FREQ/(BAUD_RATE*16) must be at least 2");
  end

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_t            state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 os_tick;
  logic                 start_edge_c;
  logic                 os_clear_c;

  assign start_edge_c = !rx_s_q && rx_prev_q;
  assign os_clear_c   = (state_q == IDLE) || (state_q == WAIT_HIGH);

  uart_os_tick_gen #(
    .DIV (OS_DIV)
  ) u_os_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (os_clear_c),
    .tick  (os_tick)
  );

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Frame FSM next state, bit counters, shift register and output pulses.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_idx_d  = '0;
        if (start_edge_c) begin
          state_d = START;
        end
      end
      START: begin
        if (os_tick) begin
          if (tick_cnt_q == TICK_W'(START_SAMPLE_TICK - 1)) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = rx_s_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      DATA: begin
        if (os_tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
            shift_d[bit_idx_q] = rx_s_q;
            if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
              bit_idx_d = '0;
              state_d   = STOP;
            end else begin
              bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
            end
          end
        end
      end
      STOP: begin
        if (os_tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = WAIT_HIGH;
            end
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = err_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed plus random frames, pulses checked against a frame-level model.
module tb_uart_rx;

  // Scaled clock so a frame is a few hundred cycles: OS_DIV = 768000/(9600*16) = 5.
  localparam int unsigned CLK_FREQ  = 768_000;
  localparam int unsigned BAUD_RATE = 9600;
  localparam int OSD  = CLK_FREQ / (BAUD_RATE * 16);
  localparam int BITP = OSD * 16;
  localparam int LAT  = 152 * OSD + 1;   // start edge E to pulse cycle
  localparam int SYNC = 2;               // pin change to E
  localparam int HIST = 32768;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         err;
    logic [7:0] data;
  } pulse_t;

  pulse_t     got_q[$];
  pulse_t     exp_q[$];
  bit         busy_hist [HIST];
  int         viol = 0;
  logic       prev_pulse = 1'b0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_good = 8'h00;

  // Observe outputs mid-cycle: record busy history, pulses, and pulse-rule violations.
  always @(negedge clk) begin
    if (cyc < HIST) busy_hist[cyc] = rx_busy;
    if (rx_valid === 1'b1 && rx_frame_err === 1'b1) viol++;
    if ((rx_valid === 1'b1 || rx_frame_err === 1'b1) && prev_pulse) viol++;
    prev_pulse = (rx_valid === 1'b1) || (rx_frame_err === 1'b1);
    if (prev_pulse) got_q.push_back('{cyc, rx_frame_err, rx_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame and record what the receiver must report for it.
  task automatic send(input logic [7:0] d, input int per, input logic stop, output int fall);
    fall = cyc;
    hold(1'b0, per);
    for (int i = 0; i < 8; i++) hold(d[i], per);
    hold(stop, per);
    if (stop) begin
      exp_q.push_back('{fall + SYNC + LAT, 1'b0, d});
      last_good = d;
    end else begin
      exp_q.push_back('{fall + SYNC + LAT, 1'b1, last_good});
    end
  endtask

  initial begin
    int         f;
    int         f2;
    int         e;
    int         r;
    logic [7:0] d;
    int         per;
    logic       stop;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(rx_data), 32'h00);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_err",   32'(rx_frame_err), 0);
    chk("rst_busy",  32'(rx_busy), 0);
    rst = 1'b0;
    hold(1'b1, 20);

    // Single good frame and busy window.
    send(8'h55, BITP, 1'b1, f);
    hold(1'b1, 60);
    e = f + SYNC;
    chk("t1_busy_at_e",      32'(busy_hist[e]), 0);
    chk("t1_busy_e_plus1",   32'(busy_hist[e + 1]), 1);
    chk("t1_busy_pre_pulse", 32'(busy_hist[e + LAT - 1]), 1);
    chk("t1_busy_at_pulse",  32'(busy_hist[e + LAT]), 0);

    // Back-to-back frames with no idle gap.
    send(8'hA3, BITP, 1'b1, f);
    send(8'h0F, BITP, 1'b1, f2);
    hold(1'b1, 60);

    // Low glitch shorter than half a bit is rejected at the start-bit sample.
    f = cyc;
    hold(1'b0, 4 * OSD);
    hold(1'b1, 3 * BITP);
    e = f + SYNC;
    chk("t3_busy_at_sample",  32'(busy_hist[e + 8 * OSD]), 1);
    chk("t3_busy_after_rej",  32'(busy_hist[e + 8 * OSD + 1]), 0);
    chk("t3_no_glitch_pulse", 32'(got_q.size()), 32'(exp_q.size()));
    send(8'h3C, BITP, 1'b1, f);
    hold(1'b1, 60);

    // Stop bit low followed by a held-low break.
    send(8'h81, BITP, 1'b0, f);
    hold(1'b0, 400);
    r = cyc;
    hold(1'b1, 40);
    chk("t4_busy_in_break", 32'(busy_hist[f + SYNC + LAT + 100]), 1);
    chk("t4_busy_rise_p2",  32'(busy_hist[r + 2]), 1);
    chk("t4_busy_rise_p3",  32'(busy_hist[r + 3]), 0);
    chk("t4_pulse_count",   32'(got_q.size()), 32'(exp_q.size()));

    // Reset in the middle of bit 4 aborts the frame silently.
    d = 8'h96;
    hold(1'b0, BITP);
    for (int i = 0; i < 4; i++) hold(d[i], BITP);
    hold(d[4], BITP / 2);
    chk("t5_busy_mid_frame", 32'(rx_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_data",  32'(rx_data), 32'h00);
    chk("t5_rst_valid", 32'(rx_valid), 0);
    chk("t5_rst_err",   32'(rx_frame_err), 0);
    chk("t5_rst_busy",  32'(rx_busy), 0);
    rst = 1'b0;
    last_good = 8'h00;
    hold(1'b1, 5 * BITP);
    chk("t5_no_pulse", 32'(got_q.size()), 32'(exp_q.size()));
    send(8'hC7, BITP, 1'b1, f);
    hold(1'b1, 60);

    // Baud mismatch of +/-2.5%.
    send(8'h5A, BITP + BITP / 40, 1'b1, f);
    hold(1'b1, 20);
    send(8'h5A, BITP - BITP / 40, 1'b1, f);
    hold(1'b1, 60);

    // Random frames: data, bit period within tolerance, occasional bad stop, random gaps.
    for (int k = 0; k < 8; k++) begin
      d    = 8'($urandom);
      per  = int'($urandom_range(BITP - BITP / 40, BITP + BITP / 40));
      stop = ($urandom_range(0, 3) != 0);
      send(d, per, stop, f);
      if (!stop) begin
        hold(1'b0, int'($urandom_range(0, 100)));
        hold(1'b1, int'($urandom_range(5, 20)));
      end else begin
        hold(1'b1, int'($urandom_range(0, 30)));
      end
    end
    hold(1'b1, 60);

    // Compare every observed pulse with the model, in order.
    chk("pulse_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("pulse%0d_cycle", i), 32'(got_q[i].at), 32'(exp_q[i].at));
        chk($sformatf("pulse%0d_kind", i), 32'(got_q[i].err), 32'(exp_q[i].err));
        chk($sformatf("pulse%0d_data", i), 32'(got_q[i].data), 32'(exp_q[i].data));
      end
    end
    chk("pulse_rules", 32'(viol), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
